// File: rtl/dft_axi4lite_responder_if.sv
// AXI4-lite slave bus bundle for the DFT responder; master drives requests, slave drives responses.
interface dft_axi4lite_responder_if #(
  parameter int AW = 32,
  parameter int DW = 64
);
  logic [AW-1:0]   s_awaddr;
  logic            s_awvalid;
  logic            s_awready;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic            s_wvalid;
  logic            s_wready;
  logic [1:0]      s_bresp;
  logic            s_bvalid;
  logic            s_bready;
  logic [AW-1:0]   s_araddr;
  logic            s_arvalid;
  logic            s_arready;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rvalid;
  logic            s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/dft_axi4lite_responder.sv
// AXI4-lite register front-end feeding 32 words into the DFT core and capturing 32 result words.
// Optional WAIT-state watchdog enabled by defining DFT_AXI_WATCHDOG_EN.
module dft_axi4lite_responder #(
  parameter int AW           = 32,
  parameter int DW           = 64,
  parameter int CORE_LAT_MAX = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  dft_axi4lite_responder_if.slave  axi,
  output logic                     core_next_o,
  output logic [63:0]              core_x_o,
  input  logic                     core_next_out_i,
  input  logic [63:0]              core_y_i
);

  typedef enum logic [2:0] {IDLE, FEED, WAIT, CAPT, DONE} state_t;

  state_t        state;
  logic [5:0]    cnt;
  logic          start_q, busy_q, done_q, timeout_q;
  logic [63:0]   x_mem [32];
  logic [63:0]   y_mem [32];

  logic          wr_acc, rd_acc;
  logic          wr_err, wr_x, wr_start;
  logic          rd_err;
  logic [DW-1:0] rd_data;
  logic [11:0]   wa, ra;
  logic          unused_addr;

  assign wa = axi.s_awaddr[11:0];
  assign ra = axi.s_araddr[11:0];
  assign unused_addr = &{1'b0, axi.s_awaddr[AW-1:12], axi.s_araddr[AW-1:12]};

  // Ready is offered only while the matching response slot is free; held low during reset.
  assign wr_acc        = axi.s_awvalid && axi.s_wvalid && !axi.s_bvalid && !rst_i;
  assign rd_acc        = axi.s_arvalid && !axi.s_rvalid && !rst_i;
  assign axi.s_awready = wr_acc;
  assign axi.s_wready  = wr_acc;
  assign axi.s_arready = rd_acc;

  always_comb begin
    wr_err   = 1'b1;
    wr_x     = 1'b0;
    wr_start = 1'b0;
    if (wa[2:0] == 3'b000) begin
      if (wa == 12'h000) begin
        wr_err   = busy_q;
        wr_start = !busy_q;
      end else if (wa[11:8] == 4'h1) begin
        wr_err = busy_q;
        wr_x   = !busy_q;
      end
    end
  end

  always_comb begin
    rd_err  = 1'b1;
    rd_data = '0;
    if (ra[2:0] == 3'b000) begin
      if (ra == 12'h000) begin
        rd_err  = 1'b0;
        rd_data = {63'b0, start_q};
      end else if (ra == 12'h008) begin
        rd_err  = 1'b0;
        rd_data = {61'b0, timeout_q, busy_q, done_q};
      end else if (ra[11:8] == 4'h1) begin
        rd_err  = 1'b0;
        rd_data = x_mem[ra[7:3]];
      end else if (ra[11:8] == 4'h2) begin
        rd_err  = busy_q;
        rd_data = y_mem[ra[7:3]];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      axi.s_bvalid <= 1'b0;
      axi.s_bresp  <= 2'b00;
      axi.s_rvalid <= 1'b0;
      axi.s_rresp  <= 2'b00;
      axi.s_rdata  <= '0;
    end else begin
      if (wr_acc) begin
        axi.s_bvalid <= 1'b1;
        axi.s_bresp  <= wr_err ? 2'b10 : 2'b00;
      end else if (axi.s_bready) begin
        axi.s_bvalid <= 1'b0;
      end
      if (rd_acc) begin
        axi.s_rvalid <= 1'b1;
        axi.s_rresp  <= rd_err ? 2'b10 : 2'b00;
        axi.s_rdata  <= rd_data;
      end else if (axi.s_rready) begin
        axi.s_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc && wr_x) begin
      for (int unsigned b = 0; b < DW / 8; b++) begin
        if (axi.s_wstrb[b]) x_mem[wa[7:3]][8*b +: 8] <= axi.s_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && state == CAPT) y_mem[cnt[4:0]] <= core_y_i;
  end

`ifdef DFT_AXI_WATCHDOG_EN
  localparam int WD_W = $clog2(CORE_LAT_MAX + 1);
  logic [WD_W-1:0] wd_cnt;
`else
  logic unused_lat;
  assign unused_lat = (CORE_LAT_MAX == 0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      core_next_o <= 1'b0;
      core_x_o    <= '0;
`ifdef DFT_AXI_WATCHDOG_EN
      wd_cnt      <= '0;
`endif
    end else begin
      core_next_o <= 1'b0;
      case (state)
        IDLE: ;
        FEED: begin
          if (cnt == 6'd32) begin
            core_x_o <= '0;
            state    <= WAIT;
`ifdef DFT_AXI_WATCHDOG_EN
            wd_cnt   <= '0;
`endif
          end else begin
            core_x_o <= x_mem[cnt[4:0]];
            cnt      <= cnt + 6'd1;
          end
        end
        WAIT: begin
          if (core_next_out_i) begin
            state <= CAPT;
            cnt   <= '0;
          end
`ifdef DFT_AXI_WATCHDOG_EN
          else if (wd_cnt == WD_W'(CORE_LAT_MAX - 1)) begin
            state     <= IDLE;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        CAPT: begin
          cnt <= cnt + 6'd1;
          if (cnt[4:0] == 5'd31) begin
            state  <= DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Placed after the case so a START landing in the DONE cycle still launches a new run.
      if (wr_acc && wr_start) begin
        start_q <= axi.s_wdata[0];
        if (!start_q && axi.s_wdata[0]) begin
          state       <= FEED;
          cnt         <= '0;
          core_next_o <= 1'b1;
          busy_q      <= 1'b1;
          done_q      <= 1'b0;
          timeout_q   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dft_axi4lite_responder.sv
// Scoreboard bench for dft_axi4lite_responder with a loopback core model (Y = X).
module tb_dft_axi4lite_responder;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [31:0] A_START  = 32'h000;
  localparam logic [31:0] A_STATUS = 32'h008;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  r;
    bit          cd;
    int          id;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_next_o;
  logic [63:0] core_x_o;
  logic        core_next_out;
  logic [63:0] core_y;

  int n_cmp = 0;
  int n_err = 0;
  int n_next = 0;
  int rid = 0;
  bit model_en = 1'b1;
  logic [63:0] last_rdata;
  logic [63:0] cap [32];
  logic [1:0]  bq [$];
  rexp_t       rq [$];

  always #5 clk = ~clk;

  dft_axi4lite_responder_if #(.AW(32), .DW(64)) axi ();

  dft_axi4lite_responder #(.AW(32), .DW(64), .CORE_LAT_MAX(16)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .axi             (axi),
    .core_next_o     (core_next_o),
    .core_x_o        (core_x_o),
    .core_next_out_i (core_next_out),
    .core_y_i        (core_y)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] xpat(input int j);
    return {16'(4*j+3), 16'(4*j+2), 16'(4*j+1), 16'(4*j)};
  endfunction

  function automatic logic [31:0] xa(input int j);
    return 32'(256 + 8*j);
  endfunction

  function automatic logic [31:0] ya(input int j);
    return 32'(512 + 8*j);
  endfunction

  task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] st,
                    input logic [1:0] er);
    bit acc = 1'b0;
    @(posedge clk); #1;
    bq.push_back(er);
    axi.s_awaddr = a; axi.s_wdata = d; axi.s_wstrb = st;
    axi.s_awvalid = 1'b1; axi.s_wvalid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (axi.s_awready) acc = 1'b1;
    end
    @(posedge clk); #1;
    axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
    if (!acc) check("aw_timeout", 64'd0, 64'd1);
  endtask

  task automatic rd(input logic [31:0] a, input logic [63:0] d, input logic [1:0] er, input bit cd);
    bit acc = 1'b0;
    rexp_t e;
    @(posedge clk); #1;
    e.d = d; e.r = er; e.cd = cd; e.id = rid++;
    rq.push_back(e);
    axi.s_araddr = a; axi.s_arvalid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (axi.s_arready) acc = 1'b1;
    end
    @(posedge clk); #1;
    axi.s_arvalid = 1'b0;
    if (!acc) check("ar_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int i = 0;
    while ((bq.size() != 0 || rq.size() != 0) && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (i >= 200) check("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic poll_done();
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      rd(A_STATUS, 64'd0, OKAY, 1'b0);
      drain();
      if (last_rdata[0]) got = 1'b1;
    end
    if (!got) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Response monitor: pops the scoreboard on every completed B/R handshake.
  always @(negedge clk) begin
    if (core_next_o) n_next++;
    if (axi.s_bvalid && axi.s_bready) begin
      if (bq.size() == 0) check("b_unexpected", 64'd1, 64'd0);
      else check("bresp", 64'(axi.s_bresp), 64'(bq.pop_front()));
    end
    if (axi.s_rvalid && axi.s_rready) begin
      last_rdata = axi.s_rdata;
      if (rq.size() == 0) check("r_unexpected", 64'd1, 64'd0);
      else begin
        rexp_t e;
        e = rq.pop_front();
        check($sformatf("rresp#%0d", e.id), 64'(axi.s_rresp), 64'(e.r));
        if (e.cd) check($sformatf("rdata#%0d", e.id), axi.s_rdata, e.d);
      end
    end
  end

  // Loopback core: records the 32 fed words and replays them 10 cycles after the last one.
  initial begin
    core_next_out = 1'b0;
    core_y = '0;
    forever begin
      @(negedge clk);
      if (core_next_o && model_en) begin
        for (int k = 0; k < 32; k++) begin
          @(negedge clk);
          cap[k] = core_x_o;
        end
        repeat (10) @(negedge clk);
        core_next_out = 1'b1;
        for (int k = 0; k < 32; k++) begin
          @(negedge clk);
          core_next_out = 1'b0;
          core_y = cap[k];
        end
        @(negedge clk);
        core_y = '0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    axi.s_awaddr = '0; axi.s_awvalid = 1'b0; axi.s_wdata = '0; axi.s_wstrb = '0;
    axi.s_wvalid = 1'b0; axi.s_bready = 1'b1; axi.s_araddr = '0; axi.s_arvalid = 1'b0;
    axi.s_rready = 1'b1;

    // Ready must stay low while reset is held, even with valid requests present.
    repeat (2) @(posedge clk);
    #1 axi.s_awvalid = 1'b1; axi.s_wvalid = 1'b1; axi.s_arvalid = 1'b1;
    @(negedge clk);
    check("awready_in_rst", 64'(axi.s_awready), 64'd0);
    check("arready_in_rst", 64'(axi.s_arready), 64'd0);
    axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0; axi.s_arvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_bvalid", 64'(axi.s_bvalid), 64'd0);
    check("rst_rvalid", 64'(axi.s_rvalid), 64'd0);
    check("rst_rdata", axi.s_rdata, 64'd0);
    check("rst_resp", 64'({axi.s_bresp, axi.s_rresp}), 64'd0);
    check("rst_next", 64'(core_next_o), 64'd0);
    check("rst_x", core_x_o, 64'd0);

    rd(A_STATUS, 64'd0, OKAY, 1'b1);
    rd(32'h300, 64'd0, SLVERR, 1'b1);
    wr(32'h104, 64'h1234, 8'hFF, SLVERR);
    rd(32'h00C, 64'd0, SLVERR, 1'b1);
    rd(A_START, 64'd0, OKAY, 1'b1);
    drain();

    for (int j = 0; j < 32; j++) wr(xa(j), xpat(j), 8'hFF, OKAY);
    rd(xa(0), xpat(0), OKAY, 1'b1);
    rd(xa(31), xpat(31), OKAY, 1'b1);
    drain();

    wr(A_START, 64'd1, 8'hFF, OKAY);
    wr(xa(0), 64'hDEAD_BEEF_0000_0000, 8'hFF, SLVERR);
    rd(ya(0), 64'd0, SLVERR, 1'b0);
    wr(A_START, 64'd1, 8'hFF, SLVERR);
    rd(A_STATUS, 64'd2, OKAY, 1'b1);
    rd(A_START, 64'd1, OKAY, 1'b1);
    drain();
    poll_done();
    rd(A_STATUS, 64'd1, OKAY, 1'b1);
    rd(ya(5), 64'h0017_0016_0015_0014, OKAY, 1'b1);
    for (int j = 0; j < 32; j++) rd(ya(j), xpat(j), OKAY, 1'b1);
    rd(xa(0), xpat(0), OKAY, 1'b1);
    drain();
    check("next_pulses", 64'(n_next), 64'd1);

    wr(xa(3), 64'd0, 8'hFF, OKAY);
    wr(xa(3), 64'hFFFF_FFFF_AAAA_BBBB, 8'h0F, OKAY);
    rd(xa(3), 64'h0000_0000_AAAA_BBBB, OKAY, 1'b1);
    drain();

    // Write-response backpressure: B holds and no new AW is taken.
    axi.s_bready = 1'b0;
    wr(xa(1), xpat(1), 8'hFF, OKAY);
    @(posedge clk); #1;
    axi.s_awaddr = xa(2); axi.s_wdata = xpat(2); axi.s_wstrb = 8'hFF;
    axi.s_awvalid = 1'b1; axi.s_wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bvalid_hold", 64'(axi.s_bvalid), 64'd1);
      check("bresp_hold", 64'(axi.s_bresp), 64'(OKAY));
      check("aw_blocked", 64'(axi.s_awready), 64'd0);
    end
    @(posedge clk); #1;
    axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0; axi.s_bready = 1'b1;
    drain();

    // Read-response backpressure: R and its data hold and no new AR is taken.
    axi.s_rready = 1'b0;
    rd(ya(5), 64'h0017_0016_0015_0014, OKAY, 1'b1);
    @(posedge clk); #1;
    axi.s_araddr = 32'h300; axi.s_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rvalid_hold", 64'(axi.s_rvalid), 64'd1);
      check("rdata_hold", axi.s_rdata, 64'h0017_0016_0015_0014);
      check("ar_blocked", 64'(axi.s_arready), 64'd0);
    end
    @(posedge clk); #1;
    axi.s_arvalid = 1'b0; axi.s_rready = 1'b1;
    drain();

    model_en = 1'b0;
    wr(A_START, 64'd0, 8'hFF, OKAY);
    wr(A_START, 64'd1, 8'hFF, OKAY);
    drain();
`ifdef DFT_AXI_WATCHDOG_EN
    poll_done();
    rd(A_STATUS, 64'd5, OKAY, 1'b1);
    rd(ya(5), 64'h0017_0016_0015_0014, OKAY, 1'b1);
`else
    repeat (100) @(negedge clk);
    rd(A_STATUS, 64'd2, OKAY, 1'b1);
`endif
    drain();

    // Reset in the middle of a feed.
    do_reset();
    rd(A_STATUS, 64'd0, OKAY, 1'b1);
    wr(A_START, 64'd1, 8'hFF, OKAY);
    drain();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_x", core_x_o, 64'd0);
    check("midrst_next", 64'(core_next_o), 64'd0);
    check("midrst_valid", 64'({axi.s_bvalid, axi.s_rvalid}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    rd(A_STATUS, 64'd0, OKAY, 1'b1);
    rd(A_START, 64'd0, OKAY, 1'b1);
    drain();
    @(negedge clk);
    check("idle_x", core_x_o, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
